// File: rtl/lsu_pkg.sv
// Load/store bus controller shared definitions.
// Size encodings, error codes and controller states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISAL   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SIZE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store shift/strobes and load extract/extend.
// Purely combinational so it can be reused by other memory ports.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [STRB_W-1:0] bmask;
  logic [DATA_W-1:0] dmask;
  logic [DATA_W-1:0] rsh;
  logic              sign;

  // Build access masks, shift store data up and load data down.
  always_comb begin
    bmask = '0;
    dmask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      bmask[i] = (i < (1 << size));
      dmask[8*i +: 8] = {8{bmask[i]}};
    end
    wstrb    = bmask << off;
    wdata_sh = (wdata & dmask) << {off, 3'b000};
    rsh      = rdata >> {off, 3'b000};
    sign     = 1'b0;
    unique case (size)
      SZ_B:    sign = rsh[7];
      SZ_H:    sign = rsh[15];
      SZ_W:    sign = rsh[31];
      default: sign = rsh[DATA_W-1];
    endcase
    sign      = sign & ~uns;
    rdata_ext = (rsh & dmask) | ({DATA_W{sign}} & ~dmask);
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// LSU front-end: one request at a time onto the data bus.
// Checks alignment, issues strobed access, returns aligned data.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = $clog2(STRB_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        nbytes;
  logic              size_bad;
  logic              misal;
  logic              expired;
  logic              in_req;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rdata_ext;
  logic [STRB_W-1:0] wstrb;

  assign nbytes   = 4'd1 << req_size;
  assign size_bad = 32'(nbytes) > STRB_W;
  assign misal    = (req_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
  assign expired  = TO_EN && (cnt_q >= CNT_LAST);
  assign in_req   = (state_q == ST_REQ);

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (size_q),
    .uns       (uns_q),
    .off       (addr_q[OFF_W-1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wdata_sh  (wdata_sh),
    .wstrb     (wstrb),
    .rdata_ext (rdata_ext)
  );

  // Next-state and latched-request logic for the bus FSM.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (size_bad) begin
            err_d   = ERR_SIZE;
            state_d = ST_RESP;
          end else if (misal) begin
            err_d   = ERR_MISAL;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          err_d   = ERR_OK;
          rdata_d = we_q ? '0 : rdata_ext;
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          err_d   = ERR_OK;
          rdata_d = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and request registers; reset abandons any bus activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_req_valid = in_req;
  assign mem_we        = in_req & we_q;
  assign mem_addr      = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign mem_wdata     = (in_req & we_q) ? wdata_sh : '0;
  assign mem_wstrb     = (in_req & we_q) ? wstrb : '0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed scoreboard bench for lsu_bus_ctrl.
// DATA_W=32, TIMEOUT=8.
module tb_lsu_bus_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic [1:0]    resp_err;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  logic          auto_mem = 1'b1;
  logic          force_rv = 1'b0;
  logic          rv_auto = 1'b0;
  logic          hs_pend = 1'b0;
  logic [DW-1:0] mem_word = '0;

  int checks = 0;
  int failures = 0;
  int mreq_cnt = 0;
  int resp_cnt = 0;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  assign mem_rvalid = rv_auto | force_rv;
  assign mem_rdata  = mem_word;

  lsu_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_valid) mreq_cnt <= mreq_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Memory model: one-cycle rvalid after each accepted request.
  initial begin
    forever begin
      @(negedge clk);
      rv_auto = 1'b0;
      if (hs_pend) begin
        rv_auto = 1'b1;
        hs_pend = 1'b0;
      end
      if (auto_mem && mem_req_valid && mem_req_ready) hs_pend = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input bit push,
                       input logic [1:0] e, input logic [31:0] rd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    if (push) sb.push_back(exp_t'({e, rd}));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    int   lat;
    exp_t x;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    x = sb.pop_front();
    if (lat >= 0) begin
      chk({tag, "_err"}, resp_err, x.err);
      chk({tag, "_rdata"}, resp_rdata, x.rdata);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "_drop"}, resp_valid, 1'b0);
    end
  endtask

  initial begin
    int m0;
    int r0;
    int w;
    exp_t x;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_resp_err", resp_err, 2'b00);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    rst_n = 1'b1;

    mem_word = 32'h80FF_1234;
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, 0, 1'b1, 2'b00, 32'hFFFF_FF80);
    wait_resp("lb_s", 2);
    issue(1'b0, 2'd0, 1'b1, 32'h8000_0003, 0, 1'b1, 2'b00, 32'h0000_0080);
    wait_resp("lb_u", 2);

    issue(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 1'b1,
          2'b00, 32'h0);
    chk("sh_req_valid", mem_req_valid, 1'b1);
    chk("sh_addr", mem_addr, 32'h8000_0000);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hABCD_0000);
    chk("sh_we", mem_we, 1'b1);
    wait_resp("sh", 2);

    m0 = mreq_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0001, 0, 1'b1, 2'b01, 32'h0);
    wait_resp("lw_misal", 0);
    issue(1'b0, 2'd3, 1'b0, 32'h8000_0000, 0, 1'b1, 2'b11, 32'h0);
    wait_resp("ld_size", 0);
    chk("err_no_mreq", 64'(mreq_cnt - m0), 64'd0);

    mem_word = 32'h1234_8001;
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0004, 0, 1'b1, 2'b00, 32'hFFFF_8001);
    wait_resp("lh_s", 2);

    mem_req_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0000, 0, 1'b1, 2'b10, 32'h0);
    wait_resp("tmo", 8);
    auto_mem = 1'b0;
    mem_req_ready = 1'b1;
    mem_word = 32'hFFFF_FFFF;
    @(negedge clk);
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    chk("stray_resp_valid", resp_valid, 1'b0);
    chk("stray_req_ready", req_ready, 1'b1);
    auto_mem = 1'b1;
    mem_word = 32'hDEAD_BEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0004, 0, 1'b1, 2'b00, 32'hDEAD_BEEF);
    wait_resp("lw_after_tmo", 2);

    mem_word = 32'hBEEF_1234;
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0006, 0, 1'b1, 2'b00, 32'h0000_BEEF);
    w = -1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin
        w = i;
        break;
      end
      @(negedge clk);
    end
    chk("bp_seen", 64'(w), 64'd2);
    x = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_rdata", resp_rdata, x.rdata);
      chk("bp_err", resp_err, x.err);
      chk("bp_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    wait_resp("bp", 0);

    auto_mem = 1'b0;
    r0 = resp_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, 0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    chk("wait_mreq_low", mem_req_valid, 1'b0);
    chk("wait_resp_low", resp_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_mreq", mem_req_valid, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_err", resp_err, 2'b00);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("aborted_no_resp", 64'(resp_cnt - r0), 64'd0);
    auto_mem = 1'b1;
    mem_word = 32'h55AA_33CC;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_000C, 0, 1'b1, 2'b00, 32'h55AA_33CC);
    wait_resp("lw_after_rst", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
